// File: rtl/pipelined_adder_16bit.sv
// Four-stage 16-bit adder built from 4-bit carry-lookahead slices.
// Nibble k of the sum is formed in stage k. The carry between nibbles is
// registered, and the upper operand nibbles are skewed along the pipe with it.
// Stage 4 is the output register. It can optionally saturate on signed overflow.
module pipelined_adder_16bit #(
  parameter bit SATURATE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic        c_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sum,
  output logic        c_out,
  output logic        overflow
);

  // Returns {carry_out, sum[3:0]} of a 4-bit generate/propagate lookahead slice.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Clamp toward the sign of the operands when the signed sum overflowed.
  // Overflow can only occur when both operands share a sign, so a[15] alone picks the rail.
  function automatic logic signed [15:0] saturate(input logic signed [15:0] raw,
                                                   input logic ovf,
                                                   input logic a_sign);
    logic signed [15:0] res;
    res = raw;
    if (SATURATE && ovf) begin
      res = a_sign ? 16'sh8000 : 16'sh7FFF;
    end
    return res;
  endfunction

  logic               stall;
  logic               vld_p1, vld_p2, vld_p3;
  logic [3:0]         sum_p1;
  logic [7:0]         sum_p2;
  logic [11:0]        sum_p3;
  logic               cy_p1, cy_p2, cy_p3;
  logic [15:4]        a_p1, b_p1;
  logic [15:8]        a_p2, b_p2;
  logic [15:12]       a_p3, b_p3;
  logic [4:0]         slice1, slice2, slice3, slice4;
  logic signed [15:0] raw_p4;
  logic               c15_p4;
  logic               ovf_p4;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  assign slice1 = cla4(a_in[3:0], b_in[3:0], c_in);
  assign slice2 = cla4(a_p1[7:4], b_p1[7:4], cy_p1);
  assign slice3 = cla4(a_p2[11:8], b_p2[11:8], cy_p2);
  assign slice4 = cla4(a_p3[15:12], b_p3[15:12], cy_p3);

  // The carry into bit 15 is recovered from the sum bit: s15 = a15 ^ b15 ^ c15.
  assign raw_p4 = {slice4[3:0], sum_p3};
  assign c15_p4 = slice4[3] ^ a_p3[15] ^ b_p3[15];
  assign ovf_p4 = c15_p4 ^ slice4[4];

  // Valid bits: a rigid shift that freezes completely while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      vld_p1    <= in_valid;
      vld_p2    <= vld_p1;
      vld_p3    <= vld_p2;
      out_valid <= vld_p3;
    end
  end

  // Stages 1-3 data: completed low nibbles, the inter-nibble carry, and the skewed upper operands.
  always_ff @(posedge clk) begin
    if (!stall) begin
      // stage 1: nibble 0
      sum_p1 <= slice1[3:0];
      cy_p1  <= slice1[4];
      a_p1   <= a_in[15:4];
      b_p1   <= b_in[15:4];
      // stage 2: nibble 1
      sum_p2 <= {slice2[3:0], sum_p1};
      cy_p2  <= slice2[4];
      a_p2   <= a_p1[15:8];
      b_p2   <= b_p1[15:8];
      // stage 3: nibble 2
      sum_p3 <= {slice3[3:0], sum_p2};
      cy_p3  <= slice3[4];
      a_p3   <= a_p2[15:12];
      b_p3   <= b_p2[15:12];
    end
  end

  // Stage 4 output register: loaded only by a valid result, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum      <= 16'h0000;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (!stall && vld_p3) begin
      sum      <= saturate(raw_p4, ovf_p4, a_p3[15]);
      c_out    <= slice4[4];
      overflow <= ovf_p4;
    end
  end

endmodule

// File: tb/tb_pipelined_adder_16bit.sv
// Bench for pipelined_adder_16bit. A wrapping instance and a saturating instance
// are driven in lockstep. The driver pushes hand-computed results into a queue when
// an operand is accepted. A monitor pops that queue and compares on each output transfer.
module tb_pipelined_adder_16bit;

  typedef struct packed {
    logic [15:0] raw;
    logic [15:0] sat;
    logic        co;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] a_in = 16'h0;
  logic [15:0] b_in = 16'h0;
  logic        c_in = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, c_out, overflow;
  logic        in_ready_s, out_valid_s, c_out_s, overflow_s;
  logic [15:0] sum, sum_s;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t scb[$];

  pipelined_adder_16bit #(.SATURATE(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .overflow(overflow));

  pipelined_adder_16bit #(.SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .out_valid(out_valid_s),
    .out_ready(out_ready), .sum(sum_s), .c_out(c_out_s), .overflow(overflow_s));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one operand set from the falling edge and hold it until accepted.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [15:0] raw, input logic [15:0] sat,
                      input logic co, input logic ov);
    int   waitc = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    c_in = c;
    #1;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    e.raw = raw;
    e.sat = sat;
    e.co  = co;
    e.ov  = ov;
    scb.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waitc = 0;
    while (scb.size() != 0 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk("drain_empty", 32'(scb.size()), 32'd0);
  endtask

  // Monitor: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    #1;
    if (!rst && out_valid && out_ready) begin
      chk("valid_lockstep", {31'd0, out_valid_s}, 32'd1);
      if (scb.size() == 0) begin
        chk("unexpected_output", {16'd0, sum}, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = scb.pop_front();
        chk("sum_raw", {16'd0, sum}, {16'd0, e.raw});
        chk("sum_sat", {16'd0, sum_s}, {16'd0, e.sat});
        chk("c_out", {31'd0, c_out}, {31'd0, e.co});
        chk("c_out_sat", {31'd0, c_out_s}, {31'd0, e.co});
        chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
        chk("overflow_sat", {31'd0, overflow_s}, {31'd0, e.ov});
      end
    end
  end

  initial begin
    int          cnt;
    logic [15:0] hold, hold_s;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single input latency: visible at the fourth falling edge after the accepting edge
    send(16'h1234, 16'h4321, 1'b0, 16'h5555, 16'h5555, 1'b0, 1'b0);
    cnt = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      cnt++;
    end while (!out_valid && cnt < 10);
    chk("latency", cnt, 32'd4);
    drain();

    // Directed carry / overflow / saturation vectors, back to back
    send(16'h0FFF, 16'h0000, 1'b1, 16'h1000, 16'h1000, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
    send(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 16'h8000, 1'b1, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1);
    send(16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 16'h7FFF, 1'b0, 1'b1);
    send(16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0);
    idle();
    drain();

    // Six back-to-back inputs with a three-cycle output stall
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          send(16'(k), 16'h0010, 1'b0, 16'(16'h0010 + k), 16'(16'h0010 + k), 1'b0, 1'b0);
        end
        idle();
      end
      begin
        cnt = 0;
        do begin
          @(negedge clk);
          cnt++;
        end while (!out_valid && cnt < 20);
        chk("stall_first_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        hold   = sum;
        hold_s = sum_s;
        for (int i = 0; i < 3; i++) begin
          #1;
          chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
          chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_sum_held", {16'd0, sum}, {16'd0, hold});
          chk("stall_sum_sat_held", {16'd0, sum_s}, {16'd0, hold_s});
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset while three results are in flight: nothing stale may emerge
    send(16'h0100, 16'h0200, 1'b0, 16'h0300, 16'h0300, 1'b0, 1'b0);
    send(16'h0101, 16'h0200, 1'b0, 16'h0301, 16'h0301, 1'b0, 1'b0);
    send(16'h0102, 16'h0200, 1'b0, 16'h0302, 16'h0302, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    scb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", {16'd0, sum}, 32'd0);
    chk("midrst_sum_sat", {16'd0, sum_s}, 32'd0);
    chk("midrst_c_out", {31'd0, c_out}, 32'd0);
    chk("midrst_overflow", {31'd0, overflow}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (10) @(negedge clk);

    // Pipeline still works after the mid-stream reset
    send(16'hFFFE, 16'h0003, 1'b0, 16'h0001, 16'h0001, 1'b1, 1'b0);
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck, expected completion");
    $fatal(1, "timeout");
  end

endmodule
